// File: rtl/axil_dmem_master.sv
// Data-memory AXI4-Lite master: runs one EX load/store as an AXI4-Lite read or write transaction.
// Latency: response pulse 3 cycles after request with a zero-wait slave; each slave wait cycle adds one.
// Backpressure: holds the pipeline (hold_flag_o = Hold_Ex) from request until the response cycle.
module axil_dmem_master #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [2:0]  PROT   = 3'b000
) (
  input  logic                  clk,
  input  logic                  rst,
  // EX-stage request
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_wstrb_i,
  // pipeline controller hold request
  output logic [2:0]            hold_flag_o,
  // response back to the pipeline
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  rsp_err_o,
  // AW channel
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [2:0]            m_awprot,
  // W channel
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  // B channel
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  // AR channel
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  // R channel
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp
);

  localparam int          STRB_W    = DATA_W / 8;
  localparam logic [2:0]  HOLD_NONE = 3'b000;
  localparam logic [2:0]  HOLD_EX   = 3'b100;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t              state;
  logic                aw_done;
  logic                w_done;
  logic [ADDR_W-1:0]   addr_q;

  // Handshakes seen this cycle on the write-address and write-data channels.
  logic aw_hs;
  logic w_hs;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid  && m_wready;

  // Both AXI addresses come from the single latched request address; the state
  // already records whether this is a load or a store, so 'we' needs no flop.
  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_awprot = PROT;
  assign m_arprot = PROT;

  // Hold the pipeline from the request cycle until the response cycle; the only
  // combinational term is the IDLE-state request itself.
  always_comb begin
    hold_flag_o = HOLD_NONE;
    if ((state == IDLE) && req_valid_i)
      hold_flag_o = HOLD_EX;
    else if ((state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA))
      hold_flag_o = HOLD_EX;
  end

  // Transaction FSM with all AXI and response outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            m_wdata <= req_wdata_i;
            m_wstrb <= req_wstrb_i;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (req_we_i) begin
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
              state     <= WADDR;
            end else begin
              m_arvalid <= 1'b1;
              state     <= RADDR;
            end
          end
        end

        WADDR: begin
          // AW and W retire independently; leave once both have been accepted.
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            m_bready <= 1'b1;
            state    <= WRESP;
          end
        end

        WRESP: begin
          if (m_bvalid) begin
            m_bready    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= (m_bresp != RESP_OKAY);
            state       <= RESP;
          end
        end

        RADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RDATA;
          end
        end

        RDATA: begin
          if (m_rvalid) begin
            m_rready    <= 1'b0;
            rsp_valid_o <= 1'b1;
            // Error responses never leak slave data into the pipeline.
            rsp_rdata_o <= (m_rresp == RESP_OKAY) ? m_rdata : '0;
            rsp_err_o   <= (m_rresp != RESP_OKAY);
            state       <= RESP;
          end
        end

        RESP: begin
          // The EX instruction that issued this access is still present, so a
          // request seen here is the same one and must not be re-issued.
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          m_awvalid   <= 1'b0;
          m_wvalid    <= 1'b0;
          m_bready    <= 1'b0;
          m_arvalid   <= 1'b0;
          m_rready    <= 1'b0;
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Strobe width is derived from the data width; keep the relation explicit.
  logic [STRB_W-1:0] unused_strb_width_tie;
  assign unused_strb_width_tie = m_wstrb;

endmodule

// File: tb/tb_axil_dmem_master.sv
module tb_axil_dmem_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  hold_flag;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot, m_arprot;
  logic [1:0]  m_bresp, m_rresp;

  axil_dmem_master #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .hold_flag_o(hold_flag),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs: wait cycles after valid/ready is seen, and response content.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
  logic [31:0] s_rdata = 32'h0;
  int          awc = 0, wc = 0, bc = 0, arc = 0, rc = 0;

  // Slave model: readies/valids driven 1 time unit after each rising edge.
  initial begin
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (m_awvalid) begin m_awready = (awc >= aw_dly); awc++; end else begin m_awready = 1'b0; awc = 0; end
      if (m_wvalid)  begin m_wready  = (wc  >= w_dly);  wc++;  end else begin m_wready  = 1'b0; wc  = 0; end
      if (m_bready)  begin m_bvalid  = (bc  >= b_dly);  bc++;  end else begin m_bvalid  = 1'b0; bc  = 0; end
      if (m_arvalid) begin m_arready = (arc >= ar_dly); arc++; end else begin m_arready = 1'b0; arc = 0; end
      if (m_rready)  begin m_rvalid  = (rc  >= r_dly);  rc++;  end else begin m_rvalid  = 1'b0; rc  = 0; end
      m_bresp = s_bresp;
      m_rresp = s_rresp;
      m_rdata = s_rdata;
    end
  end

  // Handshake counters and AXI valid-stability checks, sampled mid-cycle.
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [31:0] aw_pend_addr, ar_pend_addr, w_pend_data;
  always @(negedge clk) begin
    if (rst) begin
      if (aw_pend) chk("awvalid_stable", {m_awvalid, m_awaddr}, {1'b1, aw_pend_addr});
      if (w_pend)  chk("wvalid_stable",  {m_wvalid,  m_wdata},  {1'b1, w_pend_data});
      if (ar_pend) chk("arvalid_stable", {m_arvalid, m_araddr}, {1'b1, ar_pend_addr});
      if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; end
      if (m_wvalid && m_wready)   begin w_hs++;  last_wdata = m_wdata; last_wstrb = m_wstrb; end
      if (m_arvalid && m_arready) begin ar_hs++; last_araddr = m_araddr; end
    end
    aw_pend = rst && m_awvalid && !m_awready; aw_pend_addr = m_awaddr;
    w_pend  = rst && m_wvalid  && !m_wready;  w_pend_data  = m_wdata;
    ar_pend = rst && m_arvalid && !m_arready; ar_pend_addr = m_araddr;
  end

  // Scoreboard: expected responses pushed at issue, popped on each response pulse.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  // Per-cycle log of the most recent transaction, indexed by cycle from request.
  logic lg_awv[64], lg_wv[64], lg_arv[64], lg_br[64], lg_awhs[64], lg_whs[64], lg_bhs[64], lg_arhs[64];

  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input logic keep);
    exp_t e;
    int   hcnt;
    int   lat;
    logic got;
    for (int i = 0; i < 64; i++) begin
      lg_awv[i] = 0; lg_wv[i] = 0; lg_arv[i] = 0; lg_br[i] = 0;
      lg_awhs[i] = 0; lg_whs[i] = 0; lg_bhs[i] = 0; lg_arhs[i] = 0;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    hcnt = 0; lat = -1; got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (k < 64) begin
        lg_awv[k] = m_awvalid; lg_wv[k] = m_wvalid; lg_arv[k] = m_arvalid; lg_br[k] = m_bready;
        lg_awhs[k] = m_awvalid && m_awready; lg_whs[k] = m_wvalid && m_wready;
        lg_bhs[k]  = m_bvalid && m_bready;   lg_arhs[k] = m_arvalid && m_arready;
      end
      if (rsp_valid) begin
        got = 1'b1;
        lat = k;
        chk({name, "_hold_in_resp"}, hold_flag, 3'b000);
      end else begin
        if (hold_flag == 3'b100) hcnt++;
        @(posedge clk); #1;
        if (k == 0 && !keep) req_valid = 1'b0;
      end
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_hold_cycles"}, hcnt, exp_lat);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_valids"}, {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk({name, "_rsp"}, {rsp_valid, rsp_err}, 2'b0);
    chk({name, "_rdata"}, rsp_rdata, 32'h0);
    chk({name, "_hold"}, hold_flag, 3'b000);
    chk({name, "_addr"}, {m_awaddr, m_araddr}, 64'h0);
    chk({name, "_wdata"}, {m_wdata, m_wstrb}, 36'h0);
  endtask

  int aw0, w0, ar0, n, cnt;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
    #12;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait store.
    aw0 = aw_hs; w0 = w_hs;
    run_txn("st0", 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0, 3, 1'b0);
    chk("st0_aww_hs_cycle1", {lg_awhs[1], lg_whs[1]}, 2'b11);
    chk("st0_b_hs_cycle2", lg_bhs[2], 1'b1);
    chk("st0_awaddr", last_awaddr, 32'h1000_0004);
    chk("st0_wdata_wstrb", {last_wdata, last_wstrb}, {32'hDEAD_BEEF, 4'b0011});
    chk("st0_beats", {aw_hs - aw0, w_hs - w0}, {32'd1, 32'd1});
    chk("prot", {m_awprot, m_arprot}, 6'b0);

    // Load with AR accepted after 3 waits and R returned after 2 waits.
    ar_dly = 3; r_dly = 2; s_rdata = 32'h1234_5678;
    run_txn("ld0", 1'b0, 32'h2000_0000, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 8, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) if (lg_arv[i]) cnt++;
    chk("ld0_arvalid_cycles", cnt, 4);
    chk("ld0_ar_hs_cycle4", lg_arhs[4], 1'b1);
    chk("ld0_araddr", last_araddr, 32'h2000_0000);
    ar_dly = 0; r_dly = 0;

    // Store: W accepted at cycle 1, AW at cycle 4.
    aw_dly = 3; aw0 = aw_hs; w0 = w_hs;
    run_txn("st1", 1'b1, 32'h1000_0010, 32'h0BAD_F00D, 4'b1100, 32'h0, 1'b0, 6, 1'b0);
    chk("st1_wv_drop_awv_hold", {lg_wv[2], lg_awv[2]}, 2'b01);
    chk("st1_aw_hs_cycle4", lg_awhs[4], 1'b1);
    chk("st1_bready_after_aw", {lg_br[4], lg_br[5]}, 2'b01);
    chk("st1_beats", {aw_hs - aw0, w_hs - w0}, {32'd1, 32'd1});
    chk("st1_wdata_wstrb", {last_wdata, last_wstrb}, {32'h0BAD_F00D, 4'b1100});
    aw_dly = 0;

    // Load with SLVERR: data must be suppressed.
    s_rresp = 2'b10; s_rdata = 32'hFFFF_FFFF;
    run_txn("ld_err", 1'b0, 32'h2000_0040, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b0);
    s_rresp = 2'b00;

    // Store with SLVERR on B.
    s_bresp = 2'b10;
    run_txn("st_err", 1'b1, 32'h1000_0020, 32'h5555_AAAA, 4'b1111, 32'h0, 1'b1, 3, 1'b0);
    s_bresp = 2'b00;

    // Back-to-back loads with req_valid held through the response cycle.
    s_rdata = 32'hA5A5_5A5A; ar0 = ar_hs;
    run_txn("b2b_a", 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 3, 1'b1);
    chk("b2b_a_ar_count", ar_hs - ar0, 1);
    chk("b2b_a_no_ar_in_resp", lg_arv[3], 1'b0);
    run_txn("b2b_b", 1'b0, 32'h3000_0008, 32'h0, 4'h0, 32'hA5A5_5A5A, 1'b0, 3, 1'b0);
    chk("b2b_b_idle_first", lg_arv[0], 1'b0);
    chk("b2b_ar_count", ar_hs - ar0, 2);
    chk("b2b_b_araddr", last_araddr, 32'h3000_0008);

    // Asynchronous reset while waiting in RDATA: no response may follow.
    r_dly = 20;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4000_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!m_rready && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_reached_rdata", m_rready, 1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    r_dly = 0; s_rdata = 32'h0C0F_FEE0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_txn("ld_after_rst", 1'b0, 32'h4000_0004, 32'h0, 4'h0, 32'h0C0F_FEE0, 1'b0, 3, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
